// File: rtl/ahb_ram_bridge.sv
// AHB-Lite slave bridging pipelined address/data phases onto a single-port
// byte-writable data RAM. Reads issue in the address phase (zero wait) unless
// the RAM port is busy with a write data phase, which costs one stall cycle.
module ahb_ram_bridge #(
  parameter int unsigned AW = 11
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic [31:0]   HRDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic          RAM_EN,
  output logic [3:0]    RAM_WE,
  output logic [AW-1:0] RAM_A,
  output logic [31:0]   RAM_Di,
  input  logic [31:0]   RAM_Do
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RDS  = 3'd3;
  localparam logic [2:0] S_ERR1 = 3'd4;
  localparam logic [2:0] S_ERR2 = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    lanes_q, lanes_d;
  logic          write_q, write_d;

  logic          acc_c;
  logic          err_c;
  logic          ready_c;
  logic [3:0]    lanes_c;

  // Upper address bits are qualified by the system decoder; HTRANS[0] only
  // distinguishes SEQ from NONSEQ, which this slave treats identically.
  logic          unused_bits;
  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  assign acc_c   = HSEL & HREADY & HTRANS[1];
  assign ready_c = (state_q != S_RDS) && (state_q != S_ERR1);

  // Alignment / size legality of the transfer in its address phase.
  always_comb begin
    err_c = 1'b0;
    if (HSIZE > 3'd2)                             err_c = 1'b1;
    else if (HSIZE == 3'd1 && HADDR[0])           err_c = 1'b1;
    else if (HSIZE == 3'd2 && HADDR[1:0] != 2'b0) err_c = 1'b1;
  end

  // Byte-lane enables of the transfer in its address phase.
  always_comb begin
    lanes_c = 4'b1111;
    case (HSIZE[1:0])
      2'd0:    lanes_c = 4'b0001 << HADDR[1:0];
      2'd1:    lanes_c = 4'b0011 << {HADDR[1], 1'b0};
      default: lanes_c = 4'b1111;
    endcase
  end

  // Next-state and address-phase capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lanes_d = lanes_q;
    write_d = write_q;
    if (acc_c) begin
      addr_d  = HADDR[AW+1:2];
      lanes_d = lanes_c;
      write_d = HWRITE;
    end
    if (ready_c) begin
      if (!acc_c)                state_d = S_IDLE;
      else if (err_c)            state_d = S_ERR1;
      else if (HWRITE)           state_d = S_WR;
      else if (state_q == S_WR)  state_d = S_RDS;
      else                       state_d = S_RD;
    end else begin
      case (state_q)
        S_RDS:   state_d = S_RD;
        S_ERR1:  state_d = S_ERR2;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and captured address-phase registers, synchronous reset.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      lanes_q <= 4'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lanes_q <= lanes_d;
      write_q <= write_d;
    end
  end

  // Bus response and RAM port drive; RAM strobes are gated during reset.
  always_comb begin
    HRDATA    = RAM_Do;
    HREADYOUT = ready_c;
    HRESP     = 1'b0;
    RAM_EN    = 1'b0;
    RAM_WE    = 4'b0;
    RAM_A     = addr_q;
    RAM_Di    = HWDATA;
    case (state_q)
      S_WR: begin
        RAM_EN = 1'b1;
        RAM_WE = write_q ? lanes_q : 4'b0;
      end
      S_RDS: begin
        RAM_EN = 1'b1;
      end
      S_ERR1, S_ERR2: begin
        HRESP = 1'b1;
      end
      default: ;
    endcase
    if (acc_c && ready_c && !HWRITE && !err_c && state_q != S_WR) begin
      RAM_EN = 1'b1;
      RAM_A  = HADDR[AW+1:2];
    end
    if (!HRESETn) begin
      RAM_EN = 1'b0;
      RAM_WE = 4'b0;
    end
  end

endmodule

// File: tb/tb_ahb_ram_bridge.sv
// Randomized + directed bench for ahb_ram_bridge against a transfer-level
// memory model (byte lanes, wait-state and error response rules).
module tb_ahb_ram_bridge;

  localparam int unsigned AW = 11;
  localparam int unsigned NW = 2048;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic [31:0]   HRDATA;
  logic          HREADYOUT;
  logic          HRESP;
  logic          RAM_EN;
  logic [3:0]    RAM_WE;
  logic [AW-1:0] RAM_A;
  logic [31:0]   RAM_Di;
  logic [31:0]   RAM_Do = 32'd0;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [1:0]  idle;
  } xfer_t;

  xfer_t       xq[$];
  logic [31:0] ram [NW];
  logic [31:0] ref_mem [NW];
  logic        ram_loaded = 1'b0;
  int          total = 0;
  int          bad = 0;

  always #5 HCLK = ~HCLK;

  // Single slave on the bus: its ready is the bus ready.
  assign HREADY = HREADYOUT;

  ahb_ram_bridge #(.AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_Di(RAM_Di),
    .RAM_Do(RAM_Do)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // Synchronous RAM: registered read data, byte-lane writes.
  always @(posedge HCLK) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(NW); i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else if (RAM_EN) begin
      if (RAM_WE != 4'd0) begin
        for (int b = 0; b < 4; b++)
          if (RAM_WE[b]) ram[RAM_A][b*8 +: 8] <= RAM_Di[b*8 +: 8];
      end else begin
        RAM_Do <= ram[RAM_A];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic errf(input xfer_t x);
    return (x.size > 3'd2) || (x.size == 3'd1 && x.addr[0]) ||
           (x.size == 3'd2 && x.addr[1:0] != 2'b00);
  endfunction

  function automatic logic [3:0] lanes(input xfer_t x);
    int off;
    int nb;
    logic [3:0] l;
    off = int'(x.addr[1:0]);
    nb  = 1 << int'(x.size);
    l   = 4'b0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + nb) l[b] = 1'b1;
    return l;
  endfunction

  task automatic model_write(input xfer_t x);
    logic [3:0] l;
    l = lanes(x);
    for (int b = 0; b < 4; b++)
      if (l[b]) ref_mem[x.addr[12:2]][b*8 +: 8] = x.wdata[b*8 +: 8];
  endtask

  task automatic push(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                      input logic [31:0] wd, input logic [1:0] idle);
    xfer_t t;
    t.addr = a; t.size = sz; t.wr = wr; t.wdata = wd; t.idle = idle;
    xq.push_back(t);
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'd0; HWRITE = 1'b0; HSIZE = 3'd0;
  endtask

  // Pipelined master: runs the queued transfers, checking each data phase.
  // Entered and left at posedge+1 with the DUT ready and the bus idle.
  task automatic run_q();
    int    cyc;
    int    dp_exp;
    int    dp_wt;
    logic  adv;
    logic  ap_v;
    logic  dp_v;
    logic  last_ok;
    xfer_t ap;
    xfer_t dp;
    xfer_t t;
    cyc = 0; dp_exp = 0; dp_wt = 0; adv = 1'b1; ap_v = 1'b0; dp_v = 1'b0;
    ap = '0; dp = '0;
    forever begin
      if (adv) begin
        if (ap_v)
          dp_exp = errf(ap) ? 1 : ((!ap.wr && dp_v && dp.wr && !errf(dp)) ? 1 : 0);
        dp_v = ap_v; dp = ap; dp_wt = 0; ap_v = 1'b0;
        if (xq.size() > 0) begin
          t = xq.pop_front();
          if (t.idle > 2'd0) begin
            t.idle = t.idle - 2'd1;
            xq.push_front(t);
          end else begin
            ap = t; ap_v = 1'b1;
          end
        end
      end else begin
        dp_wt++;
      end
      if (!ap_v && !dp_v && xq.size() == 0) break;
      if (ap_v) begin
        HSEL = 1'b1; HTRANS = {1'b1, 1'($urandom)}; HADDR = ap.addr;
        HWRITE = ap.wr; HSIZE = ap.size;
      end else begin
        HSEL = 1'($urandom);
        HTRANS = HSEL ? {1'b0, 1'($urandom)} : 2'($urandom);
        HADDR = $urandom; HWRITE = 1'($urandom); HSIZE = 3'($urandom);
      end
      HWDATA = (dp_v && dp.wr) ? dp.wdata : $urandom;
      @(negedge HCLK);
      last_ok = dp_v && dp.wr && !errf(dp);
      if (dp_v) begin
        chk("hreadyout", 32'(HREADYOUT), 32'(dp_wt >= dp_exp));
        chk("hresp", 32'(HRESP), 32'(errf(dp)));
        if (HREADYOUT && dp_wt >= dp_exp && !errf(dp)) begin
          if (dp.wr) begin
            chk("ram_we", 32'(RAM_WE), 32'(lanes(dp)));
            chk("ram_a", 32'(RAM_A), 32'(dp.addr[12:2]));
            model_write(dp);
          end else begin
            chk("hrdata", HRDATA, ref_mem[dp.addr[12:2]]);
          end
        end
      end
      if (!last_ok) chk("ram_we_quiet", 32'(RAM_WE), 32'd0);
      adv = HREADYOUT;
      cyc++;
      if (cyc > 20000 || dp_wt > 4) begin
        total++; bad++;
        $display("FAIL stall_bound: waited %0d cycles, allowed %0d", dp_wt, dp_exp);
        @(posedge HCLK); #1;
        break;
      end
      @(posedge HCLK); #1;
    end
    drive_idle();
    HWDATA = 32'd0;
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    logic [2:0]  sz;
    for (int i = 0; i < int'(NW); i++) ref_mem[i] = init_word(i);
    HRESETn = 1'b0; drive_idle(); HWDATA = 32'd0;

    // Reset: a read attempted while in reset must not reach the RAM.
    repeat (3) @(posedge HCLK);
    #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h4;
    @(negedge HCLK);
    chk("rst_en", 32'(RAM_EN), 32'd0);
    chk("rst_we", 32'(RAM_WE), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1; drive_idle();
    @(negedge HCLK);
    chk("post_rst_ready", 32'(HREADYOUT), 32'd1);
    chk("post_rst_resp", 32'(HRESP), 32'd0);
    chk("post_rst_en", 32'(RAM_EN), 32'd0);
    chk("post_rst_we", 32'(RAM_WE), 32'd0);
    chk("post_rst_rdata", HRDATA, RAM_Do);
    @(posedge HCLK); #1;

    // Directed sequences.
    push(32'h4, 3'd2, 1'b1, 32'hDEADBEEF, 2'd0);
    push(32'h4, 3'd2, 1'b0, 32'h0, 2'd0);
    push(32'h10, 3'd0, 1'b1, 32'h00000011, 2'd0);
    push(32'h11, 3'd0, 1'b1, 32'h00002200, 2'd0);
    push(32'h12, 3'd0, 1'b1, 32'h00330000, 2'd0);
    push(32'h13, 3'd0, 1'b1, 32'h44000000, 2'd0);
    push(32'h10, 3'd2, 1'b0, 32'h0, 2'd1);
    push(32'h1FFE, 3'd1, 1'b1, 32'hABCD0000, 2'd0);
    push(32'h0FFE, 3'd1, 1'b0, 32'h0, 2'd0);
    push(32'h1FFE, 3'd1, 1'b0, 32'h0, 2'd0);
    push(32'h2, 3'd2, 1'b0, 32'h0, 2'd0);
    push(32'h1, 3'd1, 1'b1, 32'h12345678, 2'd0);
    push(32'h8, 3'd2, 1'b0, 32'h0, 2'd0);
    push(32'h20, 3'd2, 1'b0, 32'h0, 2'd1);
    push(32'h24, 3'd2, 1'b0, 32'h0, 2'd0);
    push(32'h28, 3'd2, 1'b1, 32'hC0FFEE01, 2'd0);
    push(32'h28, 3'd2, 1'b0, 32'h0, 2'd0);
    run_q();

    // Random traffic in two small windows so reads hit recent writes.
    for (int n = 0; n < 400; n++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:13] = 19'd0;
      a[12:6] = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h00;
      r = $urandom_range(0, 9);
      if (r < 4)      sz = 3'd2;
      else if (r < 7) sz = 3'd1;
      else if (r < 9) sz = 3'd0;
      else            sz = 3'($urandom_range(3, 7));
      if (sz <= 3'd2 && $urandom_range(0, 4) != 0)
        a = a & ~((32'd1 << sz) - 32'd1);
      push(a, sz, 1'($urandom), $urandom,
           ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0);
    end
    run_q();

    // Reset during a write data phase drops the write.
    @(negedge HCLK);
    chk("pre_rst_ready", 32'(HREADYOUT), 32'd1);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h40;
    @(posedge HCLK); #1;
    drive_idle(); HWDATA = 32'hCAFEF00D; HRESETn = 1'b0;
    @(negedge HCLK);
    chk("wr_rst_we", 32'(RAM_WE), 32'd0);
    chk("wr_rst_en", 32'(RAM_EN), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("wr_rst_ready", 32'(HREADYOUT), 32'd1);
    chk("wr_rst_resp", 32'(HRESP), 32'd0);
    chk("wr_rst_idle_en", 32'(RAM_EN), 32'd0);
    @(posedge HCLK); #1;
    push(32'h40, 3'd2, 1'b0, 32'h0, 2'd0);
    run_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
